// File: rtl/cache_controller_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cache_controller_pkg : shared constants, address fields and FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
package cache_controller_pkg;

  localparam int CC_WORD_LENGTH    = 32;
  localparam int CC_ADDR_WIDTH     = 15;
  localparam int CC_COUNT_WIDTH    = 16;
  localparam int CC_SETS           = 1024;
  localparam int CC_VALID          = 1;
  localparam int CC_WORDS_PER_LINE = 4;

  localparam int CC_TAG_MSB = 14;
  localparam int CC_TAG_LSB = 12;
  localparam int CC_IDX_MSB = 11;
  localparam int CC_IDX_LSB = 2;
  localparam int CC_OFF_MSB = 1;
  localparam int CC_OFF_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COMPARE  = 2'd1,
    S_FETCH    = 2'd2,
    S_ALLOCATE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cache_controller_line_fill_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cache_controller_line_fill_buffer : four-word staging buffer for a line refill
// Rev 1.0
// ----------------------------------------------------------------------------
module cache_controller_line_fill_buffer
  import cache_controller_pkg::*;
#(
  parameter int WORD_LENGTH = CC_WORD_LENGTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [1:0]             wr_idx_i,
  input  logic [WORD_LENGTH-1:0] wr_data_i,
  output logic [WORD_LENGTH-1:0] fill_data1_o,
  output logic [WORD_LENGTH-1:0] fill_data2_o,
  output logic [WORD_LENGTH-1:0] fill_data3_o,
  output logic [WORD_LENGTH-1:0] fill_data4_o
);

  logic [WORD_LENGTH-1:0] line_q [CC_WORDS_PER_LINE];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < CC_WORDS_PER_LINE; k++) begin
        line_q[k] <= '0;
      end
    end else if (wr_en_i) begin
      line_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign fill_data1_o = line_q[0];
  assign fill_data2_o = line_q[1];
  assign fill_data3_o = line_q[2];
  assign fill_data4_o = line_q[3];

endmodule
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cache_controller : read sequencer for a direct-mapped cache with line refill
// Rev 1.0
// ----------------------------------------------------------------------------
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int WORD_LENGTH = CC_WORD_LENGTH,
  parameter int ADDR_WIDTH  = CC_ADDR_WIDTH,
  parameter int COUNT_WIDTH = CC_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic [ADDR_WIDTH-1:0]  cpu_address,
  output logic                   cpu_ready,
  output logic [WORD_LENGTH-1:0] cpu_data,
  output logic [ADDR_WIDTH-1:0]  cache_address,
  output logic                   cache_read,
  output logic                   cache_write,
  input  logic                   cache_hit,
  input  logic [WORD_LENGTH-1:0] cache_out,
  output logic [WORD_LENGTH-1:0] fill_data1,
  output logic [WORD_LENGTH-1:0] fill_data2,
  output logic [WORD_LENGTH-1:0] fill_data3,
  output logic [WORD_LENGTH-1:0] fill_data4,
  output logic                   mem_read,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  input  logic                   mem_ready,
  input  logic [WORD_LENGTH-1:0] mem_data,
  output logic [COUNT_WIDTH-1:0] hit_count,
  output logic [COUNT_WIDTH-1:0] miss_count
);

  state_t                 state_q,    state_d;
  logic [ADDR_WIDTH-1:0]  addr_q,     addr_d;
  logic [1:0]             word_cnt_q, word_cnt_d;
  logic                   refill_q,   refill_d;
  logic [WORD_LENGTH-1:0] cpu_data_q, cpu_data_d;
  logic                   cpu_rdy_q,  cpu_rdy_d;
  logic [COUNT_WIDTH-1:0] hit_cnt_q,  hit_cnt_d;
  logic [COUNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
  logic                   buf_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      word_cnt_q <= '0;
      refill_q   <= 1'b0;
      cpu_data_q <= '0;
      cpu_rdy_q  <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      refill_q   <= refill_d;
      cpu_data_q <= cpu_data_d;
      cpu_rdy_q  <= cpu_rdy_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    word_cnt_d  = word_cnt_q;
    refill_d    = refill_q;
    cpu_data_d  = cpu_data_q;
    cpu_rdy_d   = 1'b0;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    cache_read  = 1'b0;
    cache_write = 1'b0;
    mem_read    = 1'b0;
    buf_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_address;
          state_d = S_COMPARE;
        end
      end

      S_COMPARE: begin
        cache_read = 1'b1;
        refill_d   = 1'b0;
        if (cache_hit) begin
          cpu_data_d = cache_out;
          cpu_rdy_d  = 1'b1;
          // The lookup right after a refill is the tail of a miss, not a new hit.
          if (!refill_q && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          if (miss_cnt_q != '1) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
          end
          word_cnt_d = 2'd0;
          state_d    = S_FETCH;
        end
      end

      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          buf_we     = 1'b1;
          word_cnt_d = word_cnt_q + 2'd1;
          if (word_cnt_q == 2'd3) begin
            state_d = S_ALLOCATE;
          end
        end
      end

      S_ALLOCATE: begin
        cache_write = 1'b1;
        refill_d    = 1'b1;
        state_d     = S_COMPARE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cpu_ready     = cpu_rdy_q;
  assign cpu_data      = cpu_data_q;
  assign cache_address = addr_q;
  assign mem_address   = {addr_q[ADDR_WIDTH-1:2], word_cnt_q};
  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;

  cache_controller_line_fill_buffer #(
    .WORD_LENGTH (WORD_LENGTH)
  ) u_line_fill_buffer (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (buf_we),
    .wr_idx_i     (word_cnt_q),
    .wr_data_i    (mem_data),
    .fill_data1_o (fill_data1),
    .fill_data2_o (fill_data2),
    .fill_data3_o (fill_data3),
    .fill_data4_o (fill_data4)
  );

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cache_controller : cache/memory environment with a direct-mapped hit model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cache_controller;

  localparam int WL      = 32;
  localparam int AW      = 15;
  localparam int CW      = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_address = '0;
  logic          cpu_ready;
  logic [WL-1:0] cpu_data;
  logic [AW-1:0] cache_address;
  logic          cache_read, cache_write, cache_hit;
  logic [WL-1:0] cache_out;
  logic [WL-1:0] fill_data1, fill_data2, fill_data3, fill_data4;
  logic          mem_read;
  logic [AW-1:0] mem_address;
  logic          mem_ready;
  logic [WL-1:0] mem_data;
  logic [CW-1:0] hit_count, miss_count;

  int n_cmp = 0;
  int n_bad = 0;
  int mem_lat = 0;

  always #5 clk = ~clk;

  cache_controller #(.WORD_LENGTH(WL), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_address(cpu_address),
    .cpu_ready(cpu_ready), .cpu_data(cpu_data), .cache_address(cache_address),
    .cache_read(cache_read), .cache_write(cache_write), .cache_hit(cache_hit),
    .cache_out(cache_out), .fill_data1(fill_data1), .fill_data2(fill_data2),
    .fill_data3(fill_data3), .fill_data4(fill_data4), .mem_read(mem_read),
    .mem_address(mem_address), .mem_ready(mem_ready), .mem_data(mem_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Environment cache array (not reset by the controller)
  logic [2:0]    env_tag   [1024];
  logic          env_valid [1024] = '{default: 1'b0};
  logic [WL-1:0] env_data  [1024][4];

  assign cache_hit = env_valid[cache_address[11:2]] && (env_tag[cache_address[11:2]] == cache_address[14:12]);
  assign cache_out = env_data[cache_address[11:2]][cache_address[1:0]];

  always @(posedge clk) begin
    if (cache_write) begin
      env_valid[cache_address[11:2]]   <= 1'b1;
      env_tag[cache_address[11:2]]     <= cache_address[14:12];
      env_data[cache_address[11:2]][0] <= fill_data1;
      env_data[cache_address[11:2]][1] <= fill_data2;
      env_data[cache_address[11:2]][2] <= fill_data3;
      env_data[cache_address[11:2]][3] <= fill_data4;
    end
  end

  function automatic logic [WL-1:0] mem_word(input logic [AW-1:0] a);
    return 32'd100 + WL'(a);
  endfunction

  function automatic int pick_lat();
    return (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
  endfunction

  initial begin : mem_model
    int wait_left;
    mem_ready = 1'b0;
    mem_data  = '0;
    wait_left = 0;
    forever begin
      @(negedge clk);
      if (!mem_read) begin
        mem_ready = 1'b0;
        wait_left = pick_lat();
      end else if (wait_left == 0) begin
        mem_ready = 1'b1;
        mem_data  = mem_word(mem_address);
        wait_left = pick_lat();
      end else begin
        mem_ready = 1'b0;
        wait_left--;
      end
    end
  end

  // Observation logs
  logic [AW-1:0]     mem_log [$];
  logic [AW-1:0]     wr_log  [$];
  logic [4*WL-1:0]   wr_fill [$];
  int                ready_pulses = 0;
  int                proto_viol = 0;

  always @(negedge clk) begin
    if (mem_read && mem_ready) mem_log.push_back(mem_address);
    if (cache_write) begin
      wr_log.push_back(cache_address);
      wr_fill.push_back({fill_data4, fill_data3, fill_data2, fill_data1});
    end
    if (cpu_ready) ready_pulses <= ready_pulses + 1;
    if ((cache_read && cache_write) || (mem_read && (cache_read || cache_write)))
      proto_viol <= proto_viol + 1;
  end

  // Reference model: direct-mapped tag store and saturating statistics
  logic [2:0] m_tag   [1024];
  bit         m_valid [1024];
  int         exp_hits = 0;
  int         exp_misses = 0;

  function automatic bit model_access(input logic [AW-1:0] a);
    int idx;
    bit hit;
    idx = int'(a[11:2]);
    hit = m_valid[idx] && (m_tag[idx] == a[14:12]);
    if (hit) begin
      if (exp_hits < CNT_MAX) exp_hits++;
    end else begin
      if (exp_misses < CNT_MAX) exp_misses++;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a[14:12];
    end
    return hit;
  endfunction

  task automatic do_read(input logic [AW-1:0] addr, input bit hold, input bit scramble,
                         output logic [WL-1:0] data, output int cyc, output bit timed_out);
    cpu_req     = 1'b1;
    cpu_address = addr;
    cyc         = 0;
    timed_out   = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cpu_ready) break;
      if (scramble) cpu_address = AW'($urandom);
      if (cyc >= 400) begin
        timed_out = 1'b1;
        break;
      end
    end
    data = cpu_data;
    if (!hold) cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({cpu_ready, cache_read, cache_write, mem_read} !== 4'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 0000", {cpu_ready, cache_read, cache_write, mem_read}); end
    n_cmp++; if ({cpu_data, cache_address, mem_address} !== '0) begin
      n_bad++; $display("FAIL reset_addr_data: got %h/%h/%h expected 0", cpu_data, cache_address, mem_address); end
    n_cmp++; if ({fill_data1, fill_data2, fill_data3, fill_data4, hit_count, miss_count} !== '0) begin
      n_bad++; $display("FAIL reset_fill_cnt: got fill %h %h %h %h cnt %h/%h expected 0",
                        fill_data1, fill_data2, fill_data3, fill_data4, hit_count, miss_count); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({cache_read, mem_read, cpu_ready} !== 3'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got %b expected 000", {cache_read, mem_read, cpu_ready}); end
  endtask

  task automatic test_cold_miss();
    logic [WL-1:0] d; int cyc; bit to, hit, ok; int m0, w0;
    mem_lat = 2;
    m0 = mem_log.size(); w0 = wr_log.size();
    hit = model_access(15'h0005);
    do_read(15'h0005, 1'b0, 1'b0, d, cyc, to);
    n_cmp++; if (to || d !== mem_word(15'h0005)) begin
      n_bad++; $display("FAIL cold_data: got %0d (timeout %0d) expected %0d", d, to, mem_word(15'h0005)); end
    n_cmp++; if (cyc !== (hit ? 2 : 8 + 4 * mem_lat)) begin
      n_bad++; $display("FAIL cold_latency: got %0d expected %0d", cyc, hit ? 2 : 8 + 4 * mem_lat); end
    n_cmp++; if (hit_count !== CW'(exp_hits) || miss_count !== CW'(exp_misses)) begin
      n_bad++; $display("FAIL cold_counts: got %0d/%0d expected %0d/%0d", hit_count, miss_count, exp_hits, exp_misses); end
    @(negedge clk); #1;
    n_cmp++; if (cpu_ready !== 1'b0) begin
      n_bad++; $display("FAIL cold_ready_pulse: got %b expected 0", cpu_ready); end
    ok = (mem_log.size() - m0 == 4);
    if (ok) for (int k = 0; k < 4; k++) if (mem_log[m0 + k] !== AW'(4 + k)) ok = 1'b0;
    n_cmp++; if (!ok) begin
      n_bad++; $display("FAIL cold_mem_addr: got %0d words expected 0004..0007", mem_log.size() - m0); end
    ok = (wr_log.size() - w0 == 1);
    if (ok) ok = (wr_log[w0][11:2] == 10'd1) && (wr_log[w0][14:12] == 3'd0) &&
                 (wr_fill[w0] == {mem_word(15'h7), mem_word(15'h6), mem_word(15'h5), mem_word(15'h4)});
    n_cmp++; if (!ok) begin
      n_bad++; $display("FAIL cold_line_write: got %0d writes expected 1 to index 1 tag 0 data 104..107", wr_log.size() - w0); end
  endtask

  task automatic test_hit();
    logic [WL-1:0] d; int cyc; bit to, hit; int m0;
    mem_lat = 0;
    m0 = mem_log.size();
    hit = model_access(15'h0006);
    do_read(15'h0006, 1'b0, 1'b0, d, cyc, to);
    n_cmp++; if (to || d !== mem_word(15'h0006) || cyc !== (hit ? 2 : 8)) begin
      n_bad++; $display("FAIL hit_read: got data %0d cyc %0d expected data %0d cyc %0d", d, cyc, mem_word(15'h0006), hit ? 2 : 8); end
    #1;
    n_cmp++; if (mem_log.size() !== m0 || hit_count !== CW'(exp_hits)) begin
      n_bad++; $display("FAIL hit_no_fetch: got %0d fetches hits %0d expected 0 fetches hits %0d", mem_log.size() - m0, hit_count, exp_hits); end
  endtask

  task automatic test_conflict();
    logic [WL-1:0] d; int cyc; bit to, hit, ok; int m0;
    mem_lat = 0;
    m0 = mem_log.size();
    hit = model_access(15'h1005);
    do_read(15'h1005, 1'b0, 1'b0, d, cyc, to);
    n_cmp++; if (to || hit || d !== mem_word(15'h1005) || cyc !== 8) begin
      n_bad++; $display("FAIL conflict_read: got data %0d cyc %0d expected data %0d cyc 8", d, cyc, mem_word(15'h1005)); end
    #1;
    ok = (mem_log.size() - m0 == 4);
    if (ok) for (int k = 0; k < 4; k++) if (mem_log[m0 + k] !== AW'(15'h1004 + k)) ok = 1'b0;
    n_cmp++; if (!ok) begin
      n_bad++; $display("FAIL conflict_mem_addr: got %0d words expected 1004..1007", mem_log.size() - m0); end
    hit = model_access(15'h0005);
    do_read(15'h0005, 1'b0, 1'b0, d, cyc, to);
    n_cmp++; if (to || d !== mem_word(15'h0005) || miss_count !== CW'(exp_misses) || hit_count !== CW'(exp_hits)) begin
      n_bad++; $display("FAIL conflict_refetch: got data %0d cnt %0d/%0d expected data %0d cnt %0d/%0d",
                        d, hit_count, miss_count, mem_word(15'h0005), exp_hits, exp_misses); end
  endtask

  task automatic test_reset_mid_fetch();
    logic [WL-1:0] d; int cyc; bit to, hit, ok; int m0, w0, waited;
    mem_lat = 1;
    m0 = mem_log.size(); w0 = wr_log.size();
    cpu_req = 1'b1; cpu_address = 15'h3009;
    waited = 0;
    while ((mem_log.size() - m0 < 2) && waited < 100) begin
      @(negedge clk); #1; waited++;
    end
    n_cmp++; if (waited >= 100 || mem_read !== 1'b1) begin
      n_bad++; $display("FAIL abort_setup: got mem_read %b after %0d cycles expected FETCH", mem_read, waited); end
    rst = 1'b0; cpu_req = 1'b0;
    #1;
    n_cmp++; if ({cpu_ready, cache_read, cache_write, mem_read} !== 4'b0 ||
                 {cpu_data, cache_address, mem_address, hit_count, miss_count} !== '0 ||
                 {fill_data1, fill_data2, fill_data3, fill_data4} !== '0) begin
      n_bad++; $display("FAIL abort_async_clear: got ctl %b addr %h mem %h fill1 %h expected all 0",
                        {cpu_ready, cache_read, cache_write, mem_read}, cache_address, mem_address, fill_data1); end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    exp_hits = 0; exp_misses = 0;
    @(negedge clk); #1;
    n_cmp++; if (wr_log.size() !== w0) begin
      n_bad++; $display("FAIL abort_no_write: got %0d writes expected 0", wr_log.size() - w0); end
    m0 = mem_log.size();
    hit = model_access(15'h3009);
    do_read(15'h3009, 1'b0, 1'b0, d, cyc, to);
    #1;
    ok = !to && !hit && (d === mem_word(15'h3009)) && (mem_log.size() - m0 == 4);
    if (ok) for (int k = 0; k < 4; k++) if (mem_log[m0 + k] !== AW'(15'h3008 + k)) ok = 1'b0;
    n_cmp++; if (!ok) begin
      n_bad++; $display("FAIL abort_refetch: got data %0d words %0d expected data %0d words 4 from 3008",
                        d, mem_log.size() - m0, mem_word(15'h3009)); end
    n_cmp++; if (miss_count !== CW'(exp_misses) || hit_count !== CW'(exp_hits)) begin
      n_bad++; $display("FAIL abort_counts: got %0d/%0d expected %0d/%0d", hit_count, miss_count, exp_hits, exp_misses); end
  endtask

  task automatic test_req_drop();
    bit hit, seen; int rp0, waited; logic [WL-1:0] d;
    mem_lat = 1;
    hit = model_access(15'h4012);
    rp0 = ready_pulses;
    cpu_req = 1'b1; cpu_address = 15'h4012;
    @(negedge clk);
    cpu_req = 1'b0;
    seen = 1'b0; waited = 0; d = '0;
    while (!seen && waited < 200) begin
      @(negedge clk); waited++;
      if (cpu_ready) begin seen = 1'b1; d = cpu_data; end
    end
    repeat (4) @(negedge clk);
    #1;
    n_cmp++; if (!seen || d !== mem_word(15'h4012) || (ready_pulses - rp0) !== 1) begin
      n_bad++; $display("FAIL req_drop: got seen %0d data %0d pulses %0d expected data %0d pulses 1",
                        seen, d, ready_pulses - rp0, mem_word(15'h4012)); end
  endtask

  task automatic test_back_to_back();
    logic [WL-1:0] d; int cyc; bit to, hit; int rp0; logic [AW-1:0] a;
    mem_lat = -1;
    rp0 = ready_pulses;
    for (int i = 0; i < 24; i++) begin
      a = AW'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      hit = model_access(a);
      do_read(a, 1'b1, 1'b1, d, cyc, to);
      n_cmp++; if (to || d !== mem_word(a) || (hit ? (cyc != 2) : (cyc < 8))) begin
        n_bad++; $display("FAIL b2b_read[%0d]: addr %h got data %0d cyc %0d expected data %0d hit %0d",
                          i, a, d, cyc, mem_word(a), hit); end
    end
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if ((ready_pulses - rp0) !== 24) begin
      n_bad++; $display("FAIL b2b_pulses: got %0d expected 24", ready_pulses - rp0); end
    n_cmp++; if (hit_count !== CW'(exp_hits) || miss_count !== CW'(exp_misses)) begin
      n_bad++; $display("FAIL b2b_counts: got %0d/%0d expected %0d/%0d", hit_count, miss_count, exp_hits, exp_misses); end
    n_cmp++; if (proto_viol !== 0) begin
      n_bad++; $display("FAIL strobe_exclusive: got %0d overlaps expected 0", proto_viol); end
  endtask

  task automatic test_saturation();
    logic [WL-1:0] d; int cyc; bit to, hit; logic [AW-1:0] a;
    mem_lat = 0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_hits = 0; exp_misses = 0;
    @(negedge clk);
    for (int i = 0; i < CNT_MAX + 8; i++) begin
      a = AW'(15'h5000 + (i % 4));
      hit = model_access(a);
      do_read(a, 1'b0, 1'b0, d, cyc, to);
      n_cmp++; if (to || d !== mem_word(a) || hit_count !== CW'(exp_hits)) begin
        n_bad++; $display("FAIL sat_hits[%0d]: got data %0d hits %0d expected data %0d hits %0d",
                          i, d, hit_count, mem_word(a), exp_hits); end
    end
    n_cmp++; if (hit_count !== {CW{1'b1}} || miss_count !== CW'(exp_misses)) begin
      n_bad++; $display("FAIL sat_hold: got %h/%h expected %h/%h", hit_count, miss_count, {CW{1'b1}}, CW'(exp_misses)); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_reset_mid_fetch();
    test_req_drop();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached with %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
`default_nettype wire
